// File: rtl/gate_bist_pkg.sv
// Shared types and helpers for the gate-set BIST engine.
// Holds the state encoding, the g_in bit positions, the vector-to-stimulus mapping and the golden gate model.
package gate_bist_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam int N_GATES = 7;
  localparam int G_AND   = 0;
  localparam int G_OR    = 1;
  localparam int G_NOR   = 2;
  localparam int G_NAND  = 3;
  localparam int G_XNOR  = 4;
  localparam int G_XOR   = 5;
  localparam int G_NOT   = 6;

  // Vectors are swept in the order 00, 10, 01, 11: a is the LSB of the index.
  function automatic logic vec_a(input logic [1:0] idx);
    return idx[0];
  endfunction

  function automatic logic vec_b(input logic [1:0] idx);
    return idx[1];
  endfunction

  function automatic logic [N_GATES-1:0] golden(input logic a, input logic b);
    logic [N_GATES-1:0] g;
    g         = '0;
    g[G_AND]  = a & b;
    g[G_OR]   = a | b;
    g[G_NOR]  = ~(a | b);
    g[G_NAND] = ~(a & b);
    g[G_XNOR] = ~(a ^ b);
    g[G_XOR]  = a ^ b;
    g[G_NOT]  = ~a;
    return g;
  endfunction

endpackage

// File: rtl/gate_golden_model.sv
// Combinational response comparator.
// Outputs the bits where the gate responses differ from the golden model, and how many bits differ.
module gate_golden_model
  import gate_bist_pkg::*;
(
  input  logic               a,
  input  logic               b,
  input  logic [N_GATES-1:0] g_in,
  output logic [N_GATES-1:0] mm,
  output logic [2:0]         mm_cnt
);

  always_comb begin
    mm     = g_in ^ golden(a, b);
    mm_cnt = '0;
    for (int i = 0; i < N_GATES; i++) begin
      mm_cnt = mm_cnt + {2'b00, mm[i]};
    end
  end

endmodule

// File: rtl/gate_bist_checker.sv
// BIST sequencer for the basic gate set.
// It sweeps the a/b truth table, samples g_in after the settle time and accumulates the fail mask and the error count.
module gate_bist_checker
  import gate_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1,
  parameter int ERR_W         = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               a_out,
  output logic               b_out,
  input  logic [N_GATES-1:0] g_in,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [N_GATES-1:0] fail_mask,
  output logic [ERR_W-1:0]   err_count,
  output logic [1:0]         vec_idx
);

  localparam int              PW          = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [PW-1:0]   LAST_PASS   = PW'(PASSES - 1);
  localparam logic [7:0]      SETTLE_LOAD = (SETTLE_CYCLES > 0) ? 8'(SETTLE_CYCLES - 1) : 8'd0;
  localparam logic [ERR_W-1:0] ERR_MAX    = '1;
  localparam state_t          VEC_ENTRY   = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

  state_t             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic               a_q, a_d, b_q, b_d;
  logic [7:0]         settle_q, settle_d;
  logic [PW-1:0]      pcnt_q, pcnt_d;
  logic [N_GATES-1:0] mask_q, mask_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               pass_q, pass_d;

  logic [N_GATES-1:0] mm;
  logic [2:0]         mm_cnt;
  logic [ERR_W:0]     err_sum;
  logic [ERR_W-1:0]   err_sat;
  logic               last_vec;

  gate_golden_model u_golden (
    .a      (a_q),
    .b      (b_q),
    .g_in   (g_in),
    .mm     (mm),
    .mm_cnt (mm_cnt)
  );

  assign last_vec = (idx_q == 2'd3) && (pcnt_q == LAST_PASS);
  assign err_sum  = {1'b0, err_q} + (ERR_W + 1)'(mm_cnt);
  assign err_sat  = err_sum[ERR_W] ? ERR_MAX : err_sum[ERR_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = VEC_ENTRY;
      SETTLE:  if (settle_q == 8'd0) state_d = SAMPLE;
      SAMPLE:  state_d = last_vec ? DONE : VEC_ENTRY;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    settle_d = settle_q;
    pcnt_d   = pcnt_q;
    mask_d   = mask_q;
    err_d    = err_q;
    pass_d   = pass_q;
    unique case (state_q)
      IDLE: if (start) begin
        idx_d    = 2'd0;
        a_d      = vec_a(2'd0);
        b_d      = vec_b(2'd0);
        settle_d = SETTLE_LOAD;
        pcnt_d   = '0;
        mask_d   = '0;
        err_d    = '0;
        pass_d   = 1'b0;
      end
      SETTLE: if (settle_q != 8'd0) settle_d = settle_q - 8'd1;
      SAMPLE: begin
        mask_d = mask_q | mm;
        err_d  = err_sat;
        // pass is resolved at the sampling edge so it is already valid during the done cycle.
        if (last_vec) begin
          pass_d = (err_sat == '0);
        end else begin
          idx_d    = idx_q + 2'd1;
          a_d      = vec_a(idx_q + 2'd1);
          b_d      = vec_b(idx_q + 2'd1);
          settle_d = SETTLE_LOAD;
          if (idx_q == 2'd3) pcnt_d = pcnt_q + PW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q    <= '0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      settle_q <= '0;
      pcnt_q   <= '0;
      mask_q   <= '0;
      err_q    <= '0;
      pass_q   <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      settle_q <= settle_d;
      pcnt_q   <= pcnt_d;
      mask_q   <= mask_d;
      err_q    <= err_d;
      pass_q   <= pass_d;
    end
  end

  always_comb begin
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    a_out     = a_q;
    b_out     = b_q;
    pass      = pass_q;
    fail_mask = mask_q;
    err_count = err_q;
    vec_idx   = idx_q;
  end

endmodule

// File: doc/gate_bist_checker.md
Name: gate_bist_checker

Overview:
Self-checking response analyser for the basic gate set (and, or, nor, nand, xnor, xor, not). It drives the shared a/b stimulus pair through the full 2-input truth table and samples the seven gate outputs after a settle delay. Each output is compared against a golden model, and the block reports a per-gate fail mask, a mismatch count and pass/done status. It replaces hand-read monitors with an on-chip built-in self-test (BIST) engine that sits beside the gate instances.

Parameters:
SETTLE_CYCLES, 2, extra cycles a vector is held before sampling (legal range 0..255)
PASSES, 1, number of full 4-vector sweeps per start (legal range >= 1)
ERR_W, 8, width of the saturating mismatch counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle request; accepted only in IDLE
a_out  output  1  stimulus bit a, registered
b_out  output  1  stimulus bit b, registered
g_in  input  7  gate responses; bit0 and, 1 or, 2 nor, 3 nand, 4 xnor, 5 xor, 6 not(a)
busy  output  1  high from the start-accept edge until the done cycle
done  output  1  one-cycle pulse when the run completes
pass  output  1  1 when err_count==0 at completion; held until the next accepted start
fail_mask  output  7  sticky per-gate mismatch flags, same bit order as g_in
err_count  output  ERR_W  total mismatching bits, saturating
vec_idx  output  2  index of the current vector

Behaviour:
- Reset (asynchronous, any state): state=IDLE; a_out=b_out=0; busy=done=pass=0; fail_mask=0; err_count=0; vec_idx=0; settle and pass counters=0. A reset mid-run aborts the run with no done pulse.
- Vector order: idx0 {a,b}=00, idx1 10, idx2 01, idx3 11, i.e. a_out=idx[0], b_out=idx[1].
- Golden model: and=a&b; or=a|b; nor=~(a|b); nand=~(a&b); xnor=~(a^b); xor=a^b; not=~a.
- FSM states:
  - IDLE: start=1 → clear fail_mask, err_count and pass; set idx=0 and drive vector 0; load settle counter; go to SETTLE; busy=1.
  - SETTLE: hold the vector for SETTLE_CYCLES cycles, then go to SAMPLE. With SETTLE_CYCLES=0 the FSM goes straight to SAMPLE.
  - SAMPLE (one cycle): compute mm = g_in ^ golden(a_out,b_out); fail_mask |= mm; err_count += popcount(mm), saturating at 2^ERR_W-1.
    - If idx==3 and the last pass is done → DONE.
    - Else advance idx (3 wraps to 0 and increments the pass counter), drive the new vector, reload the settle counter, go to SETTLE.
  - DONE (one cycle): done=1; pass=(err_count==0); busy=0 at the next edge; go to IDLE.
- Timing:
  - Each vector holds a_out/b_out stable for exactly SETTLE_CYCLES+1 cycles; g_in is sampled at the final edge.
  - Latency from the start-accept edge to the first done-high cycle is 4*PASSES*(SETTLE_CYCLES+1)+1 cycles (13 for the defaults).
- start is ignored in SETTLE, SAMPLE and DONE; there is no queueing.
- fail_mask, err_count and pass stay stable in IDLE until the next accepted start.
- After done, a_out/b_out keep the last vector (11) until the next start or reset.

Decomposition:
- Package gate_bist_pkg contains:
  - the state enum {IDLE, SETTLE, SAMPLE, DONE};
  - gate bit-index constants (G_AND=0 … G_NOT=6);
  - the vector-to-{a,b} mapping;
  - the function golden(a,b) returning 7 bits.
- One sub-module is natural: gate_golden_model, combinational, golden outputs plus a mismatch vector and its popcount. The FSM and counters stay in gate_bist_checker.

Test Plan:
1. Correct gate instances wired to g_in; pulse start → a/b sequence 00,10,01,11 with each vector held 3 cycles; done 13 cycles after accept; pass=1, err_count=0, fail_mask=0.
2. xor output stuck at 0 → mismatches at vectors 10 and 01; err_count=2, fail_mask=7'b0100000, pass=0.
3. not gate replaced by a buffer of a → mismatch on all 4 vectors; err_count=4, fail_mask=7'b1000000; with PASSES=2 → err_count=8 and done at 25 cycles.
4. start re-pulsed 5 cycles into a run → ignored; done still at cycle 13; results identical to scenario 1.
5. rst asserted 6 cycles into a run → all outputs go to 0 immediately and no done pulse occurs; a later start gives a full 13-cycle run with the correct result.
6. ERR_W=3 with all 7 outputs inverted → 28 raw mismatches; err_count saturates at 7, fail_mask=7'h7F, pass=0.
